// File: rtl/shot_fire_ctrl.sv
// Fire-key trigger for the player shot: frame-rate debounce, one shot in flight, reload delay.
// Optional build macro SHOT_AUTOFIRE_EN: holding the key re-fires once per flight+reload period.
module shot_fire_ctrl #(
  parameter int unsigned DEBOUNCE_FRAMES   = 2,
  parameter int unsigned RELOAD_FRAMES     = 60,
  parameter int unsigned MAX_FLIGHT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       fire_key,
  input  logic       game_enable,
  input  logic       fireCollision,
  output logic       fire_pressed,
  output logic       shot_ready,
  output logic [7:0] reload_count
);

  localparam int unsigned DB_W  = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [DB_W-1:0]  DB_LIMIT     = DB_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] RELOAD_LOAD  = CNT_W'(RELOAD_FRAMES);
  localparam logic [CNT_W-1:0] FLIGHT_LIMIT = CNT_W'(MAX_FLIGHT_FRAMES);

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_FLIGHT = 2'd1,
    ST_RELOAD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d, db_inc;
  logic             key_db_q, key_db_d;
  logic             release_seen_q, release_seen_d;
  logic [CNT_W-1:0] flight_cnt_q, flight_cnt_d, flight_inc;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             fire_pressed_q, fire_pressed_d;
  logic             shot_ready_q, shot_ready_d;
  logic             db_rise, release_set, fire_req;

  // Debounce: the key level only changes after DEBOUNCE_FRAMES agreeing frame samples.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    key_db_d    = key_db_q;
    db_rise     = 1'b0;
    release_set = 1'b0;
    db_inc      = db_cnt_q + DB_W'(1);
    if (startOfFrame) begin
      if (fire_key != key_db_q) begin
        if (db_inc >= DB_LIMIT) begin
          key_db_d = ~key_db_q;
          db_cnt_d = '0;
          db_rise  = ~key_db_q;
        end else begin
          db_cnt_d = db_inc;
        end
      end else begin
        db_cnt_d = '0;
      end
      // A release only counts once the key is actually read low, so a key held through reset cannot fire.
      release_set = ~fire_key & ~key_db_d;
    end
  end

`ifdef SHOT_AUTOFIRE_EN
  assign fire_req = startOfFrame & key_db_d & release_seen_q;
`else
  assign fire_req = db_rise & release_seen_q;
`endif

  // Shot lifecycle: READY -> FLIGHT (until hit or timeout) -> RELOAD (frame countdown) -> READY.
  always_comb begin
    state_d        = state_q;
    flight_cnt_d   = flight_cnt_q;
    reload_d       = reload_q;
    fire_pressed_d = 1'b0;
    release_seen_d = release_seen_q | release_set;
    flight_inc     = flight_cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_READY: begin
        if (fire_req && game_enable) begin
          state_d        = ST_FLIGHT;
          fire_pressed_d = 1'b1;
          flight_cnt_d   = '0;
          release_seen_d = 1'b0;
        end
      end
      ST_FLIGHT: begin
        if (fireCollision || (startOfFrame && (flight_inc == FLIGHT_LIMIT))) begin
          state_d      = ST_RELOAD;
          flight_cnt_d = '0;
          reload_d     = RELOAD_LOAD;
        end else if (startOfFrame) begin
          flight_cnt_d = flight_inc;
        end
      end
      ST_RELOAD: begin
        if (startOfFrame) begin
          if (reload_q <= CNT_W'(1)) begin
            state_d  = ST_READY;
            reload_d = '0;
          end else begin
            reload_d = reload_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d      = ST_READY;
        flight_cnt_d = '0;
        reload_d     = '0;
      end
    endcase

`ifdef SHOT_AUTOFIRE_EN
    release_seen_d = 1'b1;
`endif

    shot_ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_READY;
      db_cnt_q       <= '0;
      key_db_q       <= 1'b0;
      release_seen_q <= 1'b0;
      flight_cnt_q   <= '0;
      reload_q       <= '0;
      fire_pressed_q <= 1'b0;
      shot_ready_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      db_cnt_q       <= db_cnt_d;
      key_db_q       <= key_db_d;
      release_seen_q <= release_seen_d;
      flight_cnt_q   <= flight_cnt_d;
      reload_q       <= reload_d;
      fire_pressed_q <= fire_pressed_d;
      shot_ready_q   <= shot_ready_d;
    end
  end

  assign fire_pressed = fire_pressed_q;
  assign shot_ready   = shot_ready_q;
  assign reload_count = reload_q;

endmodule

// File: tb/tb_shot_fire_ctrl.sv
// Bench for shot_fire_ctrl (default parameters, autofire disabled): frame-level vector table
// plus hand-written reset/collision sequences; expected fire pulses are tracked in a cycle queue.
module tb_shot_fire_ctrl;

  localparam int FRAME_CYC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       fire_key;
  logic       game_enable;
  logic       fireCollision;
  logic       fire_pressed;
  logic       shot_ready;
  logic [7:0] reload_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_q[$];

  typedef struct {
    int n;        // frames to apply
    bit key;
    bit en;
    bit coll;     // collision on the sof cycle (only used with n=1)
    bit fire;     // a fire pulse is expected after the last frame's sof
    bit ready;    // expected shot_ready after the row
    int reload;   // expected reload_count after the row
  } vec_t;

  vec_t tbl[$];

  shot_fire_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .fire_key     (fire_key),
    .game_enable  (game_enable),
    .fireCollision(fireCollision),
    .fire_pressed (fire_pressed),
    .shot_ready   (shot_ready),
    .reload_count (reload_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every observed pulse must match the oldest expected cycle in the queue.
  always @(negedge clk) begin
    if (fire_pressed === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_fire: fire_pressed=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        chk("fire_cycle", cyc, exp_q.pop_front());
      end
      chk("ready_low_with_fire", int'(shot_ready), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input bit key, input bit en, input bit coll, input bit fire);
    startOfFrame  = 1'b1;
    fire_key      = key;
    game_enable   = en;
    fireCollision = coll;
    if (fire) exp_q.push_back(cyc + 1);
    tick();
    startOfFrame  = 1'b0;
    fireCollision = 1'b0;
    repeat (FRAME_CYC - 1) tick();
  endtask

  task automatic do_frames(input int n, input bit key);
    for (int i = 0; i < n; i++) do_frame(key, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_out(input string name, input bit ready, input int reload);
    chk({name, "_ready"}, int'(shot_ready), int'(ready));
    chk({name, "_reload"}, int'(reload_count), reload);
  endtask

  initial begin
    // n, key, en, coll, fire, ready, reload
    tbl.push_back('{3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0});   // stable low: release seen
    tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0});   // first high sample
    tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0});   // second high sample fires
    tbl.push_back('{4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0});   // in flight
    tbl.push_back('{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 60});  // collision loads reload
    tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 59});
    tbl.push_back('{58, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0});   // 60th frame: ready
    tbl.push_back('{3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0});   // held key: no refire
    tbl.push_back('{2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0});   // release
    tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0});   // one-frame glitch
    tbl.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0});   // press while disabled: dropped
    tbl.push_back('{3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0});   // not queued
    tbl.push_back('{2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0});   // fire, no collision follows
    tbl.push_back('{89, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 60});  // 90th frame: timeout
    tbl.push_back('{55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5});
    tbl.push_back('{2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3});   // press during reload: dropped
    tbl.push_back('{2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0});   // 150 frames after fire
    tbl.push_back('{2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0});

    reset         = 1'b1;
    startOfFrame  = 1'b0;
    fire_key      = 1'b0;
    game_enable   = 1'b1;
    fireCollision = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk_out("reset", 1'b1, 0);
    chk("reset_fire", int'(fire_pressed), 0);

    for (int r = 0; r < tbl.size(); r++) begin
      for (int f = 0; f < tbl[r].n; f++)
        do_frame(tbl[r].key, tbl[r].en, tbl[r].coll, tbl[r].fire && (f == tbl[r].n - 1));
      chk_out($sformatf("row%0d", r), tbl[r].ready, tbl[r].reload);
    end

    // Collision on a non-frame cycle, then collision ignored in reload.
    do_frames(2, 1'b0);
    do_frame(1'b1, 1'b1, 1'b0, 1'b0);
    do_frame(1'b1, 1'b1, 1'b0, 1'b1);
    do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    fireCollision = 1'b1;
    tick();
    fireCollision = 1'b0;
    chk_out("midframe_coll", 1'b0, 60);
    do_frame(1'b0, 1'b1, 1'b1, 1'b0);
    chk_out("reload_coll_ignored", 1'b0, 59);
    do_frames(29, 1'b0);
    chk_out("reload_30", 1'b0, 30);

    // Reset mid-reload with the key pressed: no fire until a release is read.
    fire_key = 1'b1;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("reset_mid_reload", 1'b1, 0);
    chk("reset_mid_reload_fire", int'(fire_pressed), 0);
    do_frames(5, 1'b1);
    chk_out("held_after_reset", 1'b1, 0);
    do_frames(2, 1'b0);
    do_frame(1'b1, 1'b1, 1'b0, 1'b0);
    do_frame(1'b1, 1'b1, 1'b0, 1'b1);
    chk_out("fire_after_release", 1'b0, 0);

    // Reset coinciding with a firing frame cancels the pulse.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("reset_mid_flight", 1'b1, 0);
    do_frames(3, 1'b0);
    do_frame(1'b1, 1'b1, 1'b0, 1'b0);
    startOfFrame = 1'b1;
    fire_key     = 1'b1;
    reset        = 1'b1;
    tick();
    startOfFrame = 1'b0;
    reset        = 1'b0;
    chk("cancelled_fire", int'(fire_pressed), 0);
    repeat (FRAME_CYC - 1) tick();
    do_frames(3, 1'b1);
    chk_out("after_cancel", 1'b1, 0);

    chk("pending_fires", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_fire_ctrl.md
Name: shot_fire_ctrl

Overview:
Upstream trigger stage for the player shot block. It debounces the raw fire key on frame boundaries and enforces one shot in flight plus a reload delay. It emits the single-cycle fire_pressed pulse that the shot block consumes to spawn a shot. It also exports shot_ready and the remaining reload frames for the HUD.

Parameters:
DEBOUNCE_FRAMES, 2, consecutive startOfFrame samples the key must read high (or low) before the debounced level changes; range 1..15
RELOAD_FRAMES, 60, frames after a shot ends before the next shot is allowed; range 1..255
MAX_FLIGHT_FRAMES, 90, frames after firing with no fireCollision before the shot is treated as expired; range 1..255

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per video frame
fire_key  in  1  raw fire key level, asynchronous to frames, already synchronised to clk
game_enable  in  1  high while gameplay is active; low suppresses new shots
fireCollision  in  1  shot hit something (level or pulse, any cycle)
fire_pressed  out  1  one-cycle pulse to the shot block: spawn a shot
shot_ready  out  1  high when a new shot may be fired
reload_count  out  8  remaining reload frames; 0 outside RELOAD

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset. All registers update on the rising edge of clk.
- Reset values:
  - state=READY; fire_pressed=0; reload_count=0.
  - Debounce counter=0; key_db=0.
  - release_seen=0: the key must read released after reset before the first shot.
- Debounce:
  - fire_key is sampled only on startOfFrame cycles.
  - If the sample differs from key_db, increment the debounce counter. key_db toggles when the counter reaches DEBOUNCE_FRAMES, and the counter then clears.
  - If the sample equals key_db, the counter clears.
  - release_seen sets when key_db is 0.
- Press event: key_db rising edge, i.e. the startOfFrame cycle on which key_db goes 0->1, gated by release_seen=1.
- FSM:
  - READY (shot_ready=1):
    - On a press event with game_enable=1: fire_pressed=1 in the next clk cycle, for exactly one cycle. Go to FLIGHT, flight_cnt=0, release_seen=0.
    - A press event with game_enable=0 is discarded, not queued.
  - FLIGHT (shot_ready=0):
    - flight_cnt increments on each startOfFrame.
    - fireCollision=1 in any cycle: go to RELOAD, reload_count=RELOAD_FRAMES.
    - flight_cnt reaches MAX_FLIGHT_FRAMES on a startOfFrame: go to RELOAD, same load.
    - fireCollision and the timeout in the same cycle: single transition, one load.
  - RELOAD (shot_ready=0):
    - reload_count decrements on each startOfFrame.
    - When the decrement would reach 0, go to READY with reload_count=0.
    - fireCollision is ignored here.
- fire_pressed never asserts outside the cycle after the READY->FLIGHT transition. Press events during FLIGHT or RELOAD are dropped.
- game_enable low does not abort FLIGHT or RELOAD; timers keep running.
- Reset asserted mid-FLIGHT or mid-RELOAD returns to the reset values on the next edge. Any pending fire_pressed is cancelled.
- Counter widths: 8-bit flight and reload counters, 4-bit debounce counter. No wrap is possible within the parameter ranges.

Optional Feature:
SHOT_AUTOFIRE_EN
- Defined: release_seen is treated as permanently 1. Entering READY with key_db=1 and game_enable=1 fires on the next startOfFrame cycle, pulse one cycle later. Holding the key yields one shot per (flight + reload) period.
- Undefined: each shot requires a debounced release then press, as above.

Test Plan:
1. Reset, hold fire_key=0 for 3 frames, then 1 for 2 frames (DEBOUNCE_FRAMES=2), game_enable=1 -> fire_pressed high exactly one cycle after the 2nd high-sample startOfFrame; shot_ready drops the same cycle.
2. Fire, then assert fireCollision 5 frames later -> reload_count=60, decrements each frame; shot_ready=1 exactly 60 startOfFrame pulses later, reload_count=0.
3. Fire with no collision (MAX_FLIGHT_FRAMES=90) -> RELOAD entered on the 90th startOfFrame; total 150 frames until shot_ready.
4. Key held high through FLIGHT and RELOAD -> no second fire_pressed until release and re-press (autofire undefined). With SHOT_AUTOFIRE_EN defined -> fires on the first startOfFrame in READY.
5. A 1-frame key glitch (high for one sample only) -> no fire_pressed. Press with game_enable=0 -> no pulse, state stays READY.
6. Assert reset mid-RELOAD with reload_count=30 -> next cycle state=READY, reload_count=0, shot_ready=1. An immediate key hold does not fire until a release is seen.
